// File: rtl/mesh_mon_pkg.sv
// Shared types and helpers for the mesh router handshake monitor.
// Paths are interleaved: channel i owns out path 2i and in path 2i+1.
package mesh_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    LATE = 2'd2
  } path_state_e;

  function automatic int out_path(input int ch);
    return 2 * ch;
  endfunction

  function automatic int in_path(input int ch);
    return 2 * ch + 1;
  endfunction

  // All-ones value of a w-bit latency counter (saturation point).
  function automatic int unsigned lat_sat(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/mesh_hs_path_mon.sv
// Single request/acknowledge path monitor: IDLE/WAIT/LATE tracker, latency
// counter, transfer counter, worst-case latency and sticky error flags.
module mesh_hs_path_mon
  import mesh_mon_pkg::*;
#(
  parameter int TIMEOUT = 50,
  parameter int LAT_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             ack,
  input  logic             clr_err,
  output logic [CNT_W-1:0] xfers,
  output logic [LAT_W-1:0] max_lat,
  output logic             err_timeout,
  output logic             err_spurious,
  output logic             set_evt
);

  localparam logic [LAT_W-1:0] LAT_SAT = LAT_W'(lat_sat(LAT_W));
  localparam logic [LAT_W-1:0] LAT_TO  = LAT_W'(TIMEOUT);
  localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);

  path_state_e      state_reg, state_next;
  logic [LAT_W-1:0] lat_reg, lat_next;
  logic [LAT_W-1:0] max_lat_reg, max_lat_next;
  logic [CNT_W-1:0] xfers_reg, xfers_next;
  logic             to_reg, to_next;
  logic             sp_reg, sp_next;
  logic             xfer, to_evt, sp_evt;
  logic [LAT_W-1:0] lat_inc, xfer_lat, max_base;

  always_comb begin
    state_next = state_reg;
    lat_next   = lat_reg;
    to_evt     = 1'b0;
    xfer       = req && ack;
    sp_evt     = ack && !req;
    lat_inc    = (lat_reg == LAT_SAT) ? LAT_SAT : lat_reg + LAT_ONE;
    xfer_lat   = (state_reg == IDLE) ? '0 : lat_reg;

    case (state_reg)
      IDLE: begin
        if (req && ack) begin
          // Request still high after a pop means the next packet is queued.
          state_next = WAIT;
          lat_next   = '0;
        end else if (req) begin
          lat_next = LAT_ONE;
          if (LAT_ONE == LAT_TO) begin
            to_evt     = 1'b1;
            state_next = LATE;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_next = IDLE;
          lat_next   = '0;
        end else if (ack) begin
          state_next = WAIT;
          lat_next   = '0;
        end else begin
          lat_next = lat_inc;
          if (lat_inc == LAT_TO) begin
            to_evt     = 1'b1;
            state_next = LATE;
          end
        end
      end
      LATE: begin
        if (!req) begin
          state_next = IDLE;
          lat_next   = '0;
        end else if (ack) begin
          state_next = WAIT;
          lat_next   = '0;
        end else begin
          lat_next = lat_inc;
        end
      end
      default: begin
        state_next = IDLE;
        lat_next   = '0;
      end
    endcase

    // A new event in the same cycle as clr_err wins over the clear.
    to_next  = to_evt || (to_reg && !clr_err);
    sp_next  = sp_evt || (sp_reg && !clr_err);
    set_evt  = (to_evt && (!to_reg || clr_err)) || (sp_evt && (!sp_reg || clr_err));

    max_base     = clr_err ? '0 : max_lat_reg;
    max_lat_next = (xfer && (xfer_lat > max_base)) ? xfer_lat : max_base;
    xfers_next   = xfers_reg + CNT_W'(xfer);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      lat_reg     <= '0;
      max_lat_reg <= '0;
      xfers_reg   <= '0;
      to_reg      <= 1'b0;
      sp_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      lat_reg     <= lat_next;
      max_lat_reg <= max_lat_next;
      xfers_reg   <= xfers_next;
      to_reg      <= to_next;
      sp_reg      <= sp_next;
    end
  end

  assign xfers        = xfers_reg;
  assign max_lat      = max_lat_reg;
  assign err_timeout  = to_reg;
  assign err_spurious = sp_reg;

endmodule

// File: rtl/mesh_hs_monitor.sv
// Passive handshake monitor for all mesh terminal paths: per-path trackers,
// registered statistics readout, error summary and interrupt pulse.
module mesh_hs_monitor
  import mesh_mon_pkg::*;
#(
  parameter int NUM_CH  = 16,
  parameter int TIMEOUT = 50,
  parameter int LAT_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             pndng,
  input  logic [NUM_CH-1:0]             pop,
  input  logic [NUM_CH-1:0]             pndng_i_in,
  input  logic [NUM_CH-1:0]             popin,
  input  logic                          clr_err,
  input  logic [$clog2(2*NUM_CH)-1:0]   stat_sel,
  output logic [CNT_W-1:0]              stat_xfers,
  output logic [LAT_W-1:0]              stat_max_lat,
  output logic [2*NUM_CH-1:0]           err_timeout,
  output logic [2*NUM_CH-1:0]           err_spurious,
  output logic                          err_any,
  output logic                          irq
);

  localparam int NUM_PATH = 2 * NUM_CH;

  logic [CNT_W-1:0]    xfers_all   [NUM_PATH];
  logic [LAT_W-1:0]    max_lat_all [NUM_PATH];
  logic [NUM_PATH-1:0] set_evt;
  logic [CNT_W-1:0]    stat_xfers_reg;
  logic [LAT_W-1:0]    stat_max_lat_reg;
  logic                irq_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      mesh_hs_path_mon #(
        .TIMEOUT (TIMEOUT),
        .LAT_W   (LAT_W),
        .CNT_W   (CNT_W)
      ) u_out (
        .clk          (clk),
        .reset        (reset),
        .req          (pndng[gi]),
        .ack          (pop[gi]),
        .clr_err      (clr_err),
        .xfers        (xfers_all[out_path(gi)]),
        .max_lat      (max_lat_all[out_path(gi)]),
        .err_timeout  (err_timeout[out_path(gi)]),
        .err_spurious (err_spurious[out_path(gi)]),
        .set_evt      (set_evt[out_path(gi)])
      );

      mesh_hs_path_mon #(
        .TIMEOUT (TIMEOUT),
        .LAT_W   (LAT_W),
        .CNT_W   (CNT_W)
      ) u_in (
        .clk          (clk),
        .reset        (reset),
        .req          (pndng_i_in[gi]),
        .ack          (popin[gi]),
        .clr_err      (clr_err),
        .xfers        (xfers_all[in_path(gi)]),
        .max_lat      (max_lat_all[in_path(gi)]),
        .err_timeout  (err_timeout[in_path(gi)]),
        .err_spurious (err_spurious[in_path(gi)]),
        .set_evt      (set_evt[in_path(gi)])
      );
    end
  endgenerate

  // Selects beyond the last path (non power-of-two channel counts) read 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_xfers_reg   <= '0;
      stat_max_lat_reg <= '0;
      irq_reg          <= 1'b0;
    end else begin
      irq_reg <= |set_evt;
      if (int'(stat_sel) < NUM_PATH) begin
        stat_xfers_reg   <= xfers_all[stat_sel];
        stat_max_lat_reg <= max_lat_all[stat_sel];
      end else begin
        stat_xfers_reg   <= '0;
        stat_max_lat_reg <= '0;
      end
    end
  end

  assign stat_xfers   = stat_xfers_reg;
  assign stat_max_lat = stat_max_lat_reg;
  assign err_any      = |{err_timeout, err_spurious};
  assign irq          = irq_reg;

endmodule

// File: tb/tb_mesh_hs_monitor.sv
// Directed bench for mesh_hs_monitor: latency, timeout, spurious pop,
// counter wrap, clear/event collision and asynchronous reset mid-wait.
module tb_mesh_hs_monitor;

  localparam int NUM_CH  = 16;
  localparam int TIMEOUT = 50;
  localparam int LAT_W   = 8;
  localparam int CNT_W   = 8;

  logic              clk;
  logic              reset;
  logic [NUM_CH-1:0] pndng, pop, pndng_i_in, popin;
  logic              clr_err;
  logic [4:0]        stat_sel;
  logic [CNT_W-1:0]  stat_xfers;
  logic [LAT_W-1:0]  stat_max_lat;
  logic [31:0]       err_timeout, err_spurious;
  logic              err_any, irq;

  int n_checks = 0;
  int n_fail   = 0;
  int irq_cnt  = 0;

  mesh_hs_monitor #(
    .NUM_CH  (NUM_CH),
    .TIMEOUT (TIMEOUT),
    .LAT_W   (LAT_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pndng        (pndng),
    .pop          (pop),
    .pndng_i_in   (pndng_i_in),
    .popin        (popin),
    .clr_err      (clr_err),
    .stat_sel     (stat_sel),
    .stat_xfers   (stat_xfers),
    .stat_max_lat (stat_max_lat),
    .err_timeout  (err_timeout),
    .err_spurious (err_spurious),
    .err_any      (err_any),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (irq === 1'b1) irq_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Advance n active edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_stat(input logic [4:0] sel);
    stat_sel = sel;
    tick(1);
  endtask

  int irq_base;

  initial begin
    reset = 1'b1; pndng = '0; pop = '0; pndng_i_in = '0; popin = '0;
    clr_err = 1'b0; stat_sel = '0;
    tick(2);
    reset = 1'b0;
    tick(3);

    // Idle after reset
    check("rst_xfers", stat_xfers, 0);
    check("rst_max_lat", stat_max_lat, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_err_spurious", err_spurious, 0);
    check("rst_err_any", err_any, 0);
    check("rst_irq_cnt", irq_cnt, 0);

    // Out path of channel 3, pop 10 cycles after request
    pndng[3] = 1'b1;
    tick(10);
    pop[3] = 1'b1;
    tick(1);
    pop[3] = 1'b0; pndng[3] = 1'b0;
    tick(1);
    read_stat(5'd6);
    check("ch3_xfers", stat_xfers, 1);
    check("ch3_max_lat", stat_max_lat, 10);
    check("ch3_err_any", err_any, 0);
    check("ch3_irq_cnt", irq_cnt, 0);

    // In path of channel 5 times out, then pops after saturation
    pndng_i_in[5] = 1'b1;
    tick(49);
    check("to_before", err_timeout[11], 0);
    tick(1);
    check("to_set", err_timeout, 32'h0000_0800);
    check("to_irq", irq, 1);
    check("to_err_any", err_any, 1);
    tick(1);
    check("to_irq_drop", irq, 0);
    tick(250);
    popin[5] = 1'b1;
    tick(1);
    popin[5] = 1'b0; pndng_i_in[5] = 1'b0;
    tick(1);
    read_stat(5'd11);
    check("to_xfers", stat_xfers, 1);
    check("to_max_lat_sat", stat_max_lat, 255);
    check("to_irq_cnt", irq_cnt, 1);
    check("to_still_set", err_timeout, 32'h0000_0800);

    // Spurious pop on channel 0, then clear
    pop[0] = 1'b1;
    tick(1);
    pop[0] = 1'b0;
    check("sp_set", err_spurious, 32'h0000_0001);
    check("sp_irq", irq, 1);
    tick(1);
    check("sp_irq_cnt", irq_cnt, 2);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("clr_spurious", err_spurious, 0);
    check("clr_timeout", err_timeout, 0);
    check("clr_err_any", err_any, 0);
    read_stat(5'd11);
    check("clr_keeps_xfers", stat_xfers, 1);
    check("clr_max_lat", stat_max_lat, 0);

    // Channel 7 back-to-back pops every 4 cycles, 300 times
    pndng[7] = 1'b1;
    tick(1);
    for (int i = 0; i < 300; i++) begin
      tick(3);
      pop[7] = 1'b1;
      tick(1);
      pop[7] = 1'b0;
    end
    pndng[7] = 1'b0;
    tick(1);
    read_stat(5'd14);
    check("wrap_xfers", stat_xfers, 44);
    check("wrap_max_lat", stat_max_lat, 4);
    check("wrap_err_any", err_any, 0);
    check("wrap_irq_cnt", irq_cnt, 2);

    // Timeout on path 2 coincident with clr_err; path 4 waits, then reset
    pndng[1] = 1'b1;
    tick(49);
    clr_err = 1'b1;
    pndng[2] = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("coll_to", err_timeout, 32'h0000_0004);
    check("coll_irq", irq, 1);
    tick(5);
    irq_base = irq_cnt;
    reset = 1'b1;
    #1;
    check("arst_err_timeout", err_timeout, 0);
    check("arst_err_any", err_any, 0);
    check("arst_irq", irq, 0);
    tick(1);
    reset = 1'b0;
    pndng[1] = 1'b0;
    tick(5);
    pop[2] = 1'b1;
    tick(1);
    pop[2] = 1'b0; pndng[2] = 1'b0;
    tick(1);
    read_stat(5'd4);
    check("rel_xfers", stat_xfers, 1);
    check("rel_max_lat", stat_max_lat, 5);
    check("rel_err_any", err_any, 0);
    check("rel_irq_cnt", irq_cnt, irq_base);
    read_stat(5'd2);
    check("rel_p2_xfers", stat_xfers, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
